// File: rtl/axi_rd_slave_pkg.sv
// Shared encodings for the AXI-style read responder.
package axi_pkg;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  // Requests the responder cannot serve; they still get a full-length burst of SLVERR beats.
  function automatic logic ar_illegal(logic [1:0] burst, logic [7:0] len, logic [2:0] size);
    return (burst == BURST_RSVD) || (size > 3'd3) ||
           ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction
endpackage

// File: rtl/axi_rd_slave_if.sv
// Read address/data channel plus the doubleword port to the memory model.
interface axi_rd_slave_if #(parameter int ADDR_W = 32);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic [1:0]        arburst;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic              arready;
  logic [63:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rlast;
  logic              rready;
  // Memory read port: mem_rdata must return the dword at mem_addr in the same cycle.
  logic              mem_en;
  logic [63:0]       mem_addr;
  logic [63:0]       mem_rdata;

  modport master (output araddr, arvalid, arburst, arlen, arsize, rready,
                  input  arready, rdata, rresp, rvalid, rlast);
  modport slave  (input  araddr, arvalid, arburst, arlen, arsize, rready, mem_rdata,
                  output arready, rdata, rresp, rvalid, rlast, mem_en, mem_addr);
  modport mem    (input  mem_en, mem_addr, output mem_rdata);
endinterface

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        burst,
  input  logic [7:0]        len,
  input  logic [2:0]        size,
  output logic [ADDR_W-1:0] next_addr
);
  logic [ADDR_W-1:0] step, mask, incr;

  // Step by the beat size; WRAP keeps the upper bits of the (len+1)*step aligned window.
  always_comb begin
    step = ADDR_W'(1) << size;
    mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    incr = addr + step;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~mask) | (incr & mask);
      default:     next_addr = incr;
    endcase
  end
endmodule

// File: rtl/axi_rd_slave.sv
// Instruction-fetch read responder: one burst at a time, arlen+1 dword beats.
module axi_rd_slave
  import axi_pkg::*;
#(
  parameter int LATENCY = 0,
  parameter int ADDR_W  = 32
) (
  input logic           clk,
  input logic           rst,
  axi_rd_slave_if.slave bus
);
  logic [1:0]        state;
  logic [7:0]        lat_cnt, beat_cnt, len_q;
  logic [ADDR_W-1:0] addr_q, next_addr, load_addr;
  logic [1:0]        burst_q, rresp_q;
  logic [2:0]        size_q;
  logic              err_q, err_in, load_err, load;
  logic              arready_q, rvalid_q, ar_hs, r_hs, last;
  logic [63:0]       rdata_q;

  axi_burst_addr #(.ADDR_W(ADDR_W)) u_addr (
    .addr(addr_q), .burst(burst_q), .len(len_q), .size(size_q), .next_addr(next_addr)
  );

  assign ar_hs  = bus.arvalid & arready_q;
  assign r_hs   = rvalid_q & bus.rready;
  assign last   = (beat_cnt == 8'd0);
  assign err_in = ar_illegal(bus.arburst, bus.arlen, bus.arsize);

  // Pick when a beat is loaded and from which address: straight from AR when there is
  // no latency, at the end of WAIT, or after each non-final handshake.
  always_comb begin
    load      = 1'b0;
    load_addr = addr_q;
    load_err  = err_q;
    if (state == ST_IDLE && ar_hs && LATENCY == 0) begin
      load      = 1'b1;
      load_addr = bus.araddr;
      load_err  = err_in;
    end else if (state == ST_WAIT && lat_cnt == 8'd0) begin
      load = 1'b1;
    end else if (state == ST_BURST && r_hs && !last) begin
      load      = 1'b1;
      load_addr = next_addr;
    end
  end

  assign bus.mem_en   = load & ~load_err;
  assign bus.mem_addr = 64'(load_addr) & ~64'h7;
  assign bus.arready  = arready_q;
  assign bus.rvalid   = rvalid_q;
  assign bus.rdata    = rdata_q;
  assign bus.rresp    = rresp_q;
  assign bus.rlast    = rvalid_q & last;

  // Control FSM and beat register; reset abandons any burst immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      lat_cnt   <= '0;
      beat_cnt  <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      burst_q   <= BURST_FIXED;
      size_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            arready_q <= 1'b0;
            addr_q    <= bus.araddr;
            burst_q   <= bus.arburst;
            len_q     <= bus.arlen;
            size_q    <= bus.arsize;
            err_q     <= err_in;
            beat_cnt  <= bus.arlen;
            lat_cnt   <= 8'(LATENCY - 1);
            state     <= (LATENCY == 0) ? ST_BURST : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_cnt == 8'd0) state <= ST_BURST;
          else lat_cnt <= lat_cnt - 8'd1;
        end
        ST_BURST: begin
          if (r_hs) begin
            if (last) begin
              state     <= ST_IDLE;
              arready_q <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt - 8'd1;
              addr_q   <= next_addr;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (load) begin
        rvalid_q <= 1'b1;
        rdata_q  <= load_err ? 64'd0 : bus.mem_rdata;
        rresp_q  <= load_err ? RESP_SLVERR : RESP_OKAY;
      end else if (state == ST_BURST && r_hs && last) begin
        rvalid_q <= 1'b0;
      end
    end
  end
endmodule
